// File: rtl/fsm_pkg.sv
// Shared FSM definitions: the state encoding and state width for the counting
// controller and later cores that slave to it.
package fsm_pkg;

  localparam int unsigned STATE_W = 2;

  // 2'b11 is left unencoded and treated as illegal by every decoder.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fsm_cnt_counter.sv
// Run-length counter: captures the requested length on load, counts RUN
// cycles, and flags the final cycle of the run.
module fsm_cnt_counter #(
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_is_done
);

  logic [CNT_WIDTH-1:0] num_cnt;
  logic [CNT_WIDTH-1:0] cnt;

  // Capture length and count; load wins over clear, clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_cnt <= '0;
      cnt     <= '0;
    end else if (i_load) begin
      num_cnt <= i_num_cnt;
      cnt     <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Last RUN cycle is reached when cnt hits num_cnt-1 (compared at CNT_WIDTH
  // bits); with num_cnt=0 the FSM never enters RUN, so the wrap is harmless.
  always_comb begin
    o_cnt     = cnt;
    o_is_done = (cnt == (num_cnt - CNT_WIDTH'(1)));
  end

endmodule

// File: rtl/fsm_cnt_core.sv
// Three-state Moore controller (IDLE/RUN/DONE) that runs for a captured number
// of cycles and then pulses done. Optional abort support is enabled by
// defining FSM_CNT_ABORT_EN; without it i_abort is ignored.
module fsm_cnt_core
  import fsm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt_val,
  output logic [STATE_W-1:0]   o_c_state
);

  state_t               c_state;
  state_t               n_state;
  logic                 abort_req;
  logic                 cnt_load;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_done;

`ifdef FSM_CNT_ABORT_EN
  assign abort_req = i_abort;
`else
  // Port kept for pin compatibility; masked so it never influences the FSM.
  assign abort_req = i_abort & 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state <= S_IDLE;
    end else begin
      c_state <= n_state;
    end
  end

  // Next-state decode; anything unlisted (including 2'b11) returns to IDLE.
  always_comb begin
    n_state = S_IDLE;
    case (c_state)
      S_IDLE: begin
        if (abort_req) begin
          n_state = S_IDLE;
        end else if (i_run) begin
          n_state = (i_num_cnt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort_req) begin
          n_state = S_IDLE;
        end else if (is_done) begin
          n_state = S_DONE;
        end else begin
          n_state = S_RUN;
        end
      end
      S_DONE:  n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  // Counter control: capture on an accepted start, count only in RUN, and
  // hold zero everywhere else or when the run ends or is aborted.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b1;
    if (c_state == S_IDLE) begin
      cnt_load = i_run & ~abort_req;
    end else if (c_state == S_RUN) begin
      cnt_en  = 1'b1;
      cnt_clr = is_done | abort_req;
    end
  end

  fsm_cnt_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (cnt_load),
    .i_num_cnt (i_num_cnt),
    .i_clr     (cnt_clr),
    .i_en      (cnt_en),
    .o_cnt     (cnt),
    .o_is_done (is_done)
  );

  // Moore output decode from registered state and count only.
  always_comb begin
    o_idle    = 1'b0;
    o_running = 1'b0;
    o_done    = 1'b0;
    o_cnt_val = '0;
    o_c_state = c_state;
    case (c_state)
      S_IDLE: o_idle = 1'b1;
      S_RUN: begin
        o_running = 1'b1;
        o_cnt_val = cnt;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_cnt_core.sv
// Directed bench for fsm_cnt_core (CNT_WIDTH=7). Expected output vectors are
// queued as stimulus is applied and compared one cycle later.
module tb_fsm_cnt_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_run;
  logic [6:0] i_num_cnt;
  logic       i_abort;
  logic       o_idle;
  logic       o_running;
  logic       o_done;
  logic [6:0] o_cnt_val;
  logic [1:0] o_c_state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  fsm_cnt_core #(
    .CNT_WIDTH (7)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .i_abort   (i_abort),
    .o_idle    (o_idle),
    .o_running (o_running),
    .o_done    (o_done),
    .o_cnt_val (o_cnt_val),
    .o_c_state (o_c_state)
  );

  // Vector layout: {idle, running, done, cnt_val[6:0], c_state[1:0]}
  localparam logic [11:0] E_IDLE = {1'b1, 1'b0, 1'b0, 7'd0, 2'b00};
  localparam logic [11:0] E_DONE = {1'b0, 1'b0, 1'b1, 7'd0, 2'b10};

  function automatic logic [11:0] e_run(input int c);
    logic [6:0] cv;
    cv = c[6:0];
    return {1'b0, 1'b1, 1'b0, cv, 2'b01};
  endfunction

  task automatic compare_front(input string tag);
    logic [11:0] exp_v;
    logic [11:0] act;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      exp_v = exp_q.pop_front();
      act   = {o_idle, o_running, o_done, o_cnt_val, o_c_state};
      n_checks++;
      assert (act === exp_v) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, act, exp_v);
    end
  endtask

  // Inputs are already set; expect this vector after the next rising edge.
  task automatic cyc(input logic [11:0] e, input string tag);
    exp_q.push_back(e);
    @(negedge clk);
    compare_front(tag);
  endtask

  // Expect this vector right now (no clock edge involved).
  task automatic now(input logic [11:0] e, input string tag);
    exp_q.push_back(e);
    compare_front(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    i_run     = 1'b0;
    i_num_cnt = 7'd0;
    i_abort   = 1'b0;

    // Reset state, during and after
    #3;
    now(E_IDLE, "reset_during");
    @(negedge clk);
    @(negedge clk);
    now(E_IDLE, "reset_held");
    reset_n = 1'b1;
    cyc(E_IDLE, "reset_after");

    // N=5 single-cycle start pulse
    i_num_cnt = 7'd5;
    i_run     = 1'b1;
    cyc(e_run(0), "n5_run");
    i_run = 1'b0;
    for (int c = 1; c < 5; c++) cyc(e_run(c), "n5_run");
    cyc(E_DONE, "n5_done");
    cyc(E_IDLE, "n5_idle");
    cyc(E_IDLE, "n5_idle2");

    // N=0 goes straight to DONE
    i_num_cnt = 7'd0;
    i_run     = 1'b1;
    cyc(E_DONE, "n0_done");
    i_run = 1'b0;
    cyc(E_IDLE, "n0_idle");

    // N=127 with start held, length changed mid-run, back-to-back restart
    i_num_cnt = 7'd127;
    i_run     = 1'b1;
    cyc(e_run(0), "n127_run");
    cyc(e_run(1), "n127_run");
    i_num_cnt = 7'd3;
    for (int c = 2; c < 127; c++) cyc(e_run(c), "n127_run");
    cyc(E_DONE, "n127_done");
    cyc(E_IDLE, "b2b_idle");
    cyc(e_run(0), "b2b_run");
    i_run = 1'b0;
    cyc(e_run(1), "b2b_run");
    cyc(e_run(2), "b2b_run");
    cyc(E_DONE, "b2b_done");
    cyc(E_IDLE, "b2b_idle2");

    // Asynchronous reset mid-RUN at count 2
    i_num_cnt = 7'd6;
    i_run     = 1'b1;
    cyc(e_run(0), "rst_run");
    i_run = 1'b0;
    cyc(e_run(1), "rst_run");
    cyc(e_run(2), "rst_run");
    #2;
    reset_n = 1'b0;
    #1;
    now(E_IDLE, "rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) cyc(E_IDLE, "rst_no_done");

    // Abort at count 4 of a 10-cycle run
    i_num_cnt = 7'd10;
    i_run     = 1'b1;
    cyc(e_run(0), "abort_run");
    i_run = 1'b0;
    for (int c = 1; c < 5; c++) cyc(e_run(c), "abort_run");
    i_abort = 1'b1;
`ifdef FSM_CNT_ABORT_EN
    cyc(E_IDLE, "abort_idle");
    i_abort = 1'b0;
    cyc(E_IDLE, "abort_no_done");
    cyc(E_IDLE, "abort_no_done");
`else
    cyc(e_run(5), "abort_ignored");
    i_abort = 1'b0;
    for (int c = 6; c < 10; c++) cyc(e_run(c), "abort_ignored");
    cyc(E_DONE, "abort_ignored_done");
    cyc(E_IDLE, "abort_ignored_idle");
`endif

    // Abort together with start while IDLE
    i_num_cnt = 7'd2;
    i_run     = 1'b1;
    i_abort   = 1'b1;
`ifdef FSM_CNT_ABORT_EN
    cyc(E_IDLE, "abort_prio");
    i_run   = 1'b0;
    i_abort = 1'b0;
    cyc(E_IDLE, "abort_prio_idle");
`else
    cyc(e_run(0), "abort_prio_ignored");
    i_run   = 1'b0;
    i_abort = 1'b0;
    cyc(e_run(1), "abort_prio_ignored");
    cyc(E_DONE, "abort_prio_done");
    cyc(E_IDLE, "abort_prio_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
